regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with an integrated pending-write scoreboard, the next-generation replacement for the single-issue `registers` block in the RISC-V datapath. Provides two asynchronous read ports and one clocked write port with optional write-to-read bypass. A per-register busy bit tracks in-flight producers reserved at issue and released at writeback, with a pipeline flush. Sits between decode/issue (reads, reservations) and writeback (writes).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to read ports and masks busy

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- reg_write  in  1  writeback enable
- write_reg  in  AW  writeback destination
- write_data  in  XLEN  writeback data
- read_reg1, read_reg2  in  AW  read addresses
- read_data1, read_data2  out  XLEN  read data (combinational)
- busy1, busy2  out  1  scoreboard busy for read_reg1 / read_reg2 (combinational)
- rsv_valid  in  1  reserve request from issue
- rsv_reg  in  AW  register to mark busy
- flush  in  1  clear all busy bits
- busy_count  out  $clog2(NREGS+1)  number of registers currently busy (registered)

## Operation
- Storage: NREGS × XLEN array `mem`, NREGS-bit vector `sb`, counter `busy_count`.
- Read: read_dataN = 0 if ZERO_REG and read_regN==0; else write_data if BYPASS and reg_write and write_reg==read_regN; else mem[read_regN].
- busyN = sb[read_regN], forced 0 if ZERO_REG and read_regN==0, or if BYPASS and reg_write and write_reg==read_regN.
- Write: on edge, reg_write=1 stores write_data into mem[write_reg]; ignored for reg 0 when ZERO_REG. Write with reg_write=0 changes nothing.
- Scoreboard next-state per register r, priority high to low:
  - reset: 0
  - flush: 0 (same-cycle reservation dropped; same-cycle data write still performed)
  - rsv_valid and rsv_reg==r: 1 (reserve beats a same-cycle writeback to r)
  - reg_write and write_reg==r: 0
  - else hold
- Reg 0 reservations ignored when ZERO_REG.
- Reserving an already-busy register leaves it busy (no nesting/count per register).
- Writeback to a non-busy register writes data, sb unchanged.
- busy_count = popcount of next-state sb, registered; always equals number of set bits in sb; never exceeds NREGS − ZERO_REG.

## Timing
- reset (synchronous): after the edge, every mem entry = 0, sb = 0, busy_count = 0; hence read_data* = 0, busy* = 0. reset dominates flush, reserve and write in the same cycle.
- Reads/busy: zero-cycle combinational from addresses and (with BYPASS) write port.
- Write visible on read ports the same cycle with BYPASS=1, next cycle after the edge with BYPASS=0.
- Reservation: busy visible the cycle after rsv_valid is sampled.
- Release: with BYPASS=1 busy drops combinationally in the writeback cycle; with BYPASS=0 after the edge.
- busy_count: updated one edge after the event, consistent with sb.
- No handshake stalls; every input sampled each cycle.

## Test plan
- Reset: preload reg 20 = 1024, assert reset one cycle with reg_write=1 to reg 5 -> all reads 0, busy_count 0, reg 5 still 0.
- Write/read: write 1024 to reg 20, reg_write=0 with data 1024 to reg 15 -> reg 20 reads 1024, reg 15 reads 0; BYPASS=1 writing 2048 to reg 2 while read_reg1=2 -> read_data1=2048 same cycle.
- Zero register: write 4096 to reg 0, reserve reg 0 -> read_data 0, busy 0, busy_count 0.
- Scoreboard: reserve reg 30 -> next cycle busy 1, busy_count 1; writeback 4096 to reg 30 -> busy 0 in that cycle (BYPASS=1), busy_count 0 next cycle, reads 4096.
- Simultaneous: reg 2 busy; same cycle reserve reg 2 and writeback 2048 to reg 2 -> data 2048 stored, reg 2 busy after edge; busy_count unchanged.
- Flush: reserve regs 3, 13, 31 on consecutive cycles, then flush with rsv_reg=5 -> busy_count 0, regs 5/13 not busy; repeat with BYPASS=0 checking one-cycle write visibility.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with a pending-write scoreboard: two combinational read
// ports, one clocked write port, per-register busy bits reserved at issue and released at writeback.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS),
   localparam int CW      = $clog2(NREGS + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reg_write,
   input  logic [AW-1:0]   write_reg,
   input  logic [XLEN-1:0] write_data,
   input  logic [AW-1:0]   read_reg1,
   input  logic [AW-1:0]   read_reg2,
   output logic [XLEN-1:0] read_data1,
   output logic [XLEN-1:0] read_data2,
   output logic            busy1,
   output logic            busy2,
   input  logic            rsv_valid,
   input  logic [AW-1:0]   rsv_reg,
   input  logic            flush,
   output logic [CW-1:0]   busy_count
);

   logic [XLEN-1:0] mem [NREGS];
   logic [NREGS-1:0] sb;
   logic [NREGS-1:0] sb_next;
   logic [CW-1:0]    count_next;
   logic             wr_en;
   logic             rsv_en;
   logic             fwd1;
   logic             fwd2;
   logic             zero1;
   logic             zero2;

   // Register 0 swallows both writes and reservations when it is hardwired.
   assign wr_en  = reg_write && !((ZERO_REG != 0) && (write_reg == '0));
   assign rsv_en = rsv_valid && !((ZERO_REG != 0) && (rsv_reg == '0));

   assign fwd1  = (BYPASS != 0) && reg_write && (write_reg == read_reg1);
   assign fwd2  = (BYPASS != 0) && reg_write && (write_reg == read_reg2);
   assign zero1 = (ZERO_REG != 0) && (read_reg1 == '0);
   assign zero2 = (ZERO_REG != 0) && (read_reg2 == '0);

   always_comb begin
      read_data1 = mem[read_reg1];
      busy1      = sb[read_reg1];
      if (fwd1) begin
         read_data1 = write_data;
         busy1      = 1'b0;
      end
      if (zero1) begin
         read_data1 = '0;
         busy1      = 1'b0;
      end
   end

   always_comb begin
      read_data2 = mem[read_reg2];
      busy2      = sb[read_reg2];
      if (fwd2) begin
         read_data2 = write_data;
         busy2      = 1'b0;
      end
      if (zero2) begin
         read_data2 = '0;
         busy2      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[write_reg] <= write_data;
      end
   end

   // Later assignments win: reserve overrides a same-cycle release, flush overrides both.
   always_comb begin
      sb_next = sb;
      if (wr_en)  sb_next[write_reg] = 1'b0;
      if (rsv_en) sb_next[rsv_reg]   = 1'b1;
      if (flush)  sb_next            = '0;
   end

   always_comb begin
      count_next = '0;
      for (int r = 0; r < NREGS; r++) count_next = count_next + CW'(sb_next[r]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sb         <= '0;
         busy_count <= '0;
      end else begin
         sb         <= sb_next;
         busy_count <= count_next;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized scoreboard bench for regfile_sb: one instance with bypass, one without,
// both driven identically and checked against an array-based model of the register file.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reg_write = 1'b0;
   logic [4:0]  write_reg = '0;
   logic [31:0] write_data = '0;
   logic [4:0]  read_reg1 = '0;
   logic [4:0]  read_reg2 = '0;
   logic        rsv_valid = 1'b0;
   logic [4:0]  rsv_reg = '0;
   logic        flush = 1'b0;

   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        b1_b, b2_b, b1_n, b2_n;
   logic [5:0]  bc_b, bc_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut_byp (
      .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(rd1_b), .read_data2(rd2_b), .busy1(b1_b), .busy2(b2_b),
      .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .flush(flush), .busy_count(bc_b));

   regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) dut_nob (
      .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(rd1_n), .read_data2(rd2_n), .busy1(b1_n), .busy2(b2_n),
      .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .flush(flush), .busy_count(bc_n));

   typedef struct {
      bit          chk;
      logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
      logic        b1_b, b2_b, b1_n, b2_n;
      logic [5:0]  bc;
   } exp_t;

   exp_t expq[$];

   // Reference state: architectural contents and the set of registers awaiting writeback.
   logic [31:0] m_mem [32];
   bit          m_sb  [32];
   bit          m_known = 1'b0;

   function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp, input bit we,
                                          input logic [4:0] wr, input logic [31:0] wd);
      if (a == 0) return 32'd0;
      if (byp && we && wr == a) return wd;
      return m_mem[a];
   endfunction

   function automatic bit m_busy(input logic [4:0] a, input bit byp, input bit we,
                                 input logic [4:0] wr);
      if (a == 0) return 1'b0;
      if (byp && we && wr == a) return 1'b0;
      return m_sb[a];
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_sb[i]);
      return c;
   endfunction

   task automatic drive(input bit rst, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit rv, input logic [4:0] rr, input bit fl);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; reg_write = we; write_reg = wr; write_data = wd;
      read_reg1 = r1; read_reg2 = r2; rsv_valid = rv; rsv_reg = rr; flush = fl;
      e.chk   = m_known;
      e.rd1_b = m_read(r1, 1'b1, we, wr, wd);
      e.rd2_b = m_read(r2, 1'b1, we, wr, wd);
      e.rd1_n = m_read(r1, 1'b0, we, wr, wd);
      e.rd2_n = m_read(r2, 1'b0, we, wr, wd);
      e.b1_b  = m_busy(r1, 1'b1, we, wr);
      e.b2_b  = m_busy(r2, 1'b1, we, wr);
      e.b1_n  = m_busy(r1, 1'b0, we, wr);
      e.b2_n  = m_busy(r2, 1'b0, we, wr);
      e.bc    = 6'(m_count());
      expq.push_back(e);
      // Apply the coming edge to the model.
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'd0;
            m_sb[i]  = 1'b0;
         end
         m_known = 1'b1;
      end else begin
         if (we && wr != 0) m_mem[wr] = wd;
         if (fl) begin
            for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
         end else begin
            if (we) m_sb[wr] = 1'b0;
            if (rv && rr != 0) m_sb[rr] = 1'b1;
         end
      end
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         if (e.chk) begin
            cmp("byp.read_data1", rd1_b, e.rd1_b);
            cmp("byp.read_data2", rd2_b, e.rd2_b);
            cmp("byp.busy1", 32'(b1_b), 32'(e.b1_b));
            cmp("byp.busy2", 32'(b2_b), 32'(e.b2_b));
            cmp("byp.busy_count", 32'(bc_b), 32'(e.bc));
            cmp("nob.read_data1", rd1_n, e.rd1_n);
            cmp("nob.read_data2", rd2_n, e.rd2_n);
            cmp("nob.busy1", 32'(b1_n), 32'(e.b1_n));
            cmp("nob.busy2", 32'(b2_n), 32'(e.b2_n));
            cmp("nob.busy_count", 32'(bc_n), 32'(e.bc));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      //     rst we  wr     wd       r1     r2     rv  rr     fl
      drive(1, 0, 5'd0,  32'd0,    5'd0,  5'd0,  0, 5'd0,  0);
      // preload then reset with a competing write
      drive(0, 1, 5'd20, 32'd1024, 5'd20, 5'd5,  0, 5'd0,  0);
      drive(1, 1, 5'd5,  32'd77,   5'd20, 5'd5,  1, 5'd9,  1);
      drive(0, 0, 5'd0,  32'd0,    5'd20, 5'd5,  0, 5'd0,  0);
      // write, disabled write, same-cycle forwarding
      drive(0, 1, 5'd20, 32'd1024, 5'd20, 5'd15, 0, 5'd0,  0);
      drive(0, 0, 5'd15, 32'd1024, 5'd20, 5'd15, 0, 5'd0,  0);
      drive(0, 1, 5'd2,  32'd2048, 5'd2,  5'd15, 0, 5'd0,  0);
      drive(0, 0, 5'd0,  32'd0,    5'd2,  5'd15, 0, 5'd0,  0);
      // hardwired zero register
      drive(0, 1, 5'd0,  32'd4096, 5'd0,  5'd0,  1, 5'd0,  0);
      drive(0, 0, 5'd0,  32'd0,    5'd0,  5'd0,  0, 5'd0,  0);
      // reserve then release reg 30
      drive(0, 0, 5'd0,  32'd0,    5'd30, 5'd0,  1, 5'd30, 0);
      drive(0, 0, 5'd0,  32'd0,    5'd30, 5'd0,  0, 5'd0,  0);
      drive(0, 1, 5'd30, 32'd4096, 5'd30, 5'd0,  0, 5'd0,  0);
      drive(0, 0, 5'd0,  32'd0,    5'd30, 5'd0,  0, 5'd0,  0);
      // reserve beats a same-cycle writeback
      drive(0, 0, 5'd0,  32'd0,    5'd2,  5'd0,  1, 5'd2,  0);
      drive(0, 1, 5'd2,  32'd2048, 5'd2,  5'd0,  1, 5'd2,  0);
      drive(0, 0, 5'd0,  32'd0,    5'd2,  5'd0,  0, 5'd0,  0);
      // flush drops a same-cycle reservation but keeps the data write
      drive(0, 0, 5'd0,  32'd0,    5'd3,  5'd13, 1, 5'd3,  0);
      drive(0, 0, 5'd0,  32'd0,    5'd3,  5'd13, 1, 5'd13, 0);
      drive(0, 0, 5'd0,  32'd0,    5'd3,  5'd31, 1, 5'd31, 0);
      drive(0, 1, 5'd13, 32'd99,   5'd5,  5'd13, 1, 5'd5,  1);
      drive(0, 0, 5'd0,  32'd0,    5'd5,  5'd13, 0, 5'd0,  0);
      // random traffic, addresses sometimes narrowed to force collisions
      for (int i = 0; i < 3000; i++) begin
         bit narrow;
         logic [4:0] wr, r1, r2, rr;
         narrow = ($urandom_range(0, 1) == 1);
         wr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         r1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         r2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         rr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), wr, $urandom,
               r1, r2, ($urandom_range(0, 1) == 1), rr, ($urandom_range(0, 39) == 0));
      end
      drive(0, 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 5'd0, 0);
      for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
      @(posedge clk);
      if (expq.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
